// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: accepts one memory operation at a time, checks alignment,
// drives a word-aligned request and returns extended load data for writeback.

package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef logic [4:0]  rv32i_reg;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [2:0] {
    lb  = 3'd0,
    lh  = 3'd1,
    lw  = 3'd2,
    lbu = 3'd4,
    lhu = 3'd5
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'd0,
    sh = 3'd1,
    sw = 3'd2
  } store_funct3_t;
endpackage

module rv32i_lsu
  import rv32i_types::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_is_store,
  input  logic [2:0]     req_funct3,
  input  rv32i_word      req_addr,
  input  rv32i_word      req_wdata,
  input  rv32i_reg       req_rd,
  output logic           resp_valid,
  output rv32i_word      resp_rdata,
  output rv32i_reg       resp_rd,
  output logic           resp_load_regfile,
  output logic           resp_misaligned,
  output logic           mem_read,
  output logic           mem_write,
  output rv32i_word      mem_address,
  output rv32i_mem_wmask mem_byte_enable,
  output rv32i_word      mem_wdata,
  input  rv32i_word      mem_rdata,
  input  logic           mem_resp
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t         state_reg, state_next;
  logic           is_store_reg, is_store_next;
  logic [2:0]     funct3_reg, funct3_next;
  logic [1:0]     offset_reg, offset_next;
  rv32i_reg       rd_reg, rd_next;
  logic           mem_read_reg, mem_read_next;
  logic           mem_write_reg, mem_write_next;
  rv32i_word      mem_address_reg, mem_address_next;
  rv32i_mem_wmask mem_byte_enable_reg, mem_byte_enable_next;
  rv32i_word      mem_wdata_reg, mem_wdata_next;
  logic           resp_valid_reg, resp_valid_next;
  rv32i_word      resp_rdata_reg, resp_rdata_next;
  rv32i_reg       resp_rd_reg, resp_rd_next;
  logic           resp_load_regfile_reg, resp_load_regfile_next;
  logic           resp_misaligned_reg, resp_misaligned_next;

  logic           req_err;
  rv32i_mem_wmask req_mask;
  rv32i_word      req_lane_data;
  rv32i_word      rdata_shifted;
  rv32i_word      load_data;

  // Request decode: funct3[1:0] is the access width for both loads and stores.
  always_comb begin
    req_mask      = 4'b1111;
    req_lane_data = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        req_mask      = 4'b0001 << req_addr[1:0];
        req_lane_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_mask      = 4'b0011 << req_addr[1:0];
        req_lane_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase

    req_err = 1'b1;
    if (req_is_store) begin
      case (req_funct3)
        sb:      req_err = 1'b0;
        sh:      req_err = req_addr[0];
        sw:      req_err = (req_addr[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        lb, lbu: req_err = 1'b0;
        lh, lhu: req_err = req_addr[0];
        lw:      req_err = (req_addr[1:0] != 2'b00);
        default: req_err = 1'b1;
      endcase
    end
  end

  // Bring the addressed lane down to bit 0 before extending.
  always_comb begin
    rdata_shifted = mem_rdata >> {offset_reg, 3'b000};
    case (funct3_reg)
      lb:      load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      lbu:     load_data = {24'd0, rdata_shifted[7:0]};
      lh:      load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      lhu:     load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  always_comb begin
    state_next             = state_reg;
    is_store_next          = is_store_reg;
    funct3_next            = funct3_reg;
    offset_next            = offset_reg;
    rd_next                = rd_reg;
    mem_read_next          = mem_read_reg;
    mem_write_next         = mem_write_reg;
    mem_address_next       = mem_address_reg;
    mem_byte_enable_next   = mem_byte_enable_reg;
    mem_wdata_next         = mem_wdata_reg;
    resp_valid_next        = 1'b0;
    resp_rdata_next        = resp_rdata_reg;
    resp_rd_next           = resp_rd_reg;
    resp_load_regfile_next = resp_load_regfile_reg;
    resp_misaligned_next   = resp_misaligned_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          is_store_next = req_is_store;
          funct3_next   = req_funct3;
          offset_next   = req_addr[1:0];
          rd_next       = req_rd;
          if (req_err) begin
            state_next             = RESPOND;
            resp_valid_next        = 1'b1;
            resp_rdata_next        = '0;
            resp_rd_next           = req_rd;
            resp_load_regfile_next = 1'b0;
            resp_misaligned_next   = 1'b1;
          end else begin
            state_next           = ACCESS;
            mem_read_next        = ~req_is_store;
            mem_write_next       = req_is_store;
            mem_address_next     = {req_addr[31:2], 2'b00};
            mem_byte_enable_next = req_mask;
            mem_wdata_next       = req_lane_data;
          end
        end
      end
      ACCESS: begin
        if (mem_resp) begin
          state_next             = RESPOND;
          mem_read_next          = 1'b0;
          mem_write_next         = 1'b0;
          resp_valid_next        = 1'b1;
          resp_rdata_next        = is_store_reg ? '0 : load_data;
          resp_rd_next           = rd_reg;
          resp_load_regfile_next = ~is_store_reg & (rd_reg != 5'd0);
          resp_misaligned_next   = 1'b0;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg             <= IDLE;
      is_store_reg          <= 1'b0;
      funct3_reg            <= 3'd0;
      offset_reg            <= 2'd0;
      rd_reg                <= '0;
      mem_read_reg          <= 1'b0;
      mem_write_reg         <= 1'b0;
      mem_address_reg       <= '0;
      mem_byte_enable_reg   <= '0;
      mem_wdata_reg         <= '0;
      resp_valid_reg        <= 1'b0;
      resp_rdata_reg        <= '0;
      resp_rd_reg           <= '0;
      resp_load_regfile_reg <= 1'b0;
      resp_misaligned_reg   <= 1'b0;
    end else begin
      state_reg             <= state_next;
      is_store_reg          <= is_store_next;
      funct3_reg            <= funct3_next;
      offset_reg            <= offset_next;
      rd_reg                <= rd_next;
      mem_read_reg          <= mem_read_next;
      mem_write_reg         <= mem_write_next;
      mem_address_reg       <= mem_address_next;
      mem_byte_enable_reg   <= mem_byte_enable_next;
      mem_wdata_reg         <= mem_wdata_next;
      resp_valid_reg        <= resp_valid_next;
      resp_rdata_reg        <= resp_rdata_next;
      resp_rd_reg           <= resp_rd_next;
      resp_load_regfile_reg <= resp_load_regfile_next;
      resp_misaligned_reg   <= resp_misaligned_next;
    end
  end

  assign req_ready         = (state_reg == IDLE);
  assign mem_read          = mem_read_reg;
  assign mem_write         = mem_write_reg;
  assign mem_address       = mem_address_reg;
  assign mem_byte_enable   = mem_byte_enable_reg;
  assign mem_wdata         = mem_wdata_reg;
  assign resp_valid        = resp_valid_reg;
  assign resp_rdata        = resp_rdata_reg;
  assign resp_rd           = resp_rd_reg;
  assign resp_load_regfile = resp_load_regfile_reg;
  assign resp_misaligned   = resp_misaligned_reg;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed cases plus randomized operations
// compared against a byte-level reference model of loads, stores and alignment.

module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_load_regfile, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        mem_read, mem_write, mem_resp;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_enable;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_lsu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_is_store      (req_is_store),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_rd            (req_rd),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_rd           (resp_rd),
    .resp_load_regfile (resp_load_regfile),
    .resp_misaligned   (resp_misaligned),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_address       (mem_address),
    .mem_byte_enable   (mem_byte_enable),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_resp          (mem_resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: access size and alignment straight from the ISA rules, data by byte lanes.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output bit err, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int size;
    int a;
    bit sgn;
    a    = int'(addr % 4);
    size = 0;
    sgn  = 0;
    if (st) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    if (size == 0) err = 1;
    else err = (a % size) != 0;
    be = '0;
    wd = '0;
    ld = '0;
    if (!err) begin
      for (int i = 0; i < size; i++) be[a + i] = 1'b1;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
      for (int i = 0; i < size; i++) ld[8*i +: 8] = rdata[8*(a + i) +: 8];
      if (sgn && ld[8*size - 1])
        for (int i = size; i < 4; i++) ld[8*i +: 8] = 8'hFF;
    end
    if (st) ld = '0;
  endfunction

  // Runs one operation starting at a negedge with the LSU idle; lat = wait cycles before mem_resp.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input int lat,
                         output logic [31:0] got_rdata, output logic [3:0] got_be,
                         output logic [31:0] got_wd);
    bit          err;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    model(st, f3, addr, wdata, rdata, err, be, wd, ld);
    got_be = '0;
    got_wd = '0;
    check("ready_before", req_ready, 1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    @(negedge clk);
    // Junk request held while busy must never be taken.
    req_is_store = ~st;
    req_funct3   = 3'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_rd       = 5'($urandom);
    if (!err) begin
      got_be = mem_byte_enable;
      got_wd = mem_wdata;
      for (int k = 0; k <= lat; k++) begin
        check("mem_read", mem_read, !st);
        check("mem_write", mem_write, st);
        check("mem_address", mem_address, {addr[31:2], 2'b00});
        check("mem_be", mem_byte_enable, be);
        if (st) check("mem_wdata", mem_wdata, wd);
        check("ready_busy", req_ready, 0);
        check("resp_valid_busy", resp_valid, 0);
        mem_resp  = (k == lat);
        mem_rdata = (k == lat) ? rdata : $urandom;
        @(negedge clk);
      end
      mem_resp  = 1'b0;
      mem_rdata = $urandom;
    end
    check("resp_valid", resp_valid, 1);
    check("resp_misaligned", resp_misaligned, err);
    check("resp_rdata", resp_rdata, ld);
    check("resp_rd", resp_rd, rd);
    check("resp_load_regfile", resp_load_regfile, !st && !err && rd != 5'd0);
    check("strobe_read_off", mem_read, 0);
    check("strobe_write_off", mem_write, 0);
    check("ready_in_resp", req_ready, 0);
    got_rdata = resp_rdata;
    mem_resp  = 1'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    mem_resp  = 1'b0;
    check("resp_valid_pulse", resp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, wd;
    logic [3:0]  be;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'd0;
    req_addr     = '0;
    req_wdata    = '0;
    req_rd       = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    #2;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_be", mem_byte_enable, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_rd", resp_rd, 0);
    check("rst_resp_lrf", resp_load_regfile, 0);
    check("rst_resp_mis", resp_misaligned, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 0, r, be, wd);
    check("lw_value", r, 32'hDEADBEEF);
    check("lw_be", be, 4'b1111);
    run_txn(0, 3'd0, 32'h103, 32'h0, 32'h80112233, 5'd3, 1, r, be, wd);
    check("lb_value", r, 32'hFFFFFF80);
    run_txn(0, 3'd4, 32'h103, 32'h0, 32'h80112233, 5'd3, 0, r, be, wd);
    check("lbu_value", r, 32'h00000080);
    run_txn(0, 3'd1, 32'h102, 32'h0, 32'h80112233, 5'd4, 2, r, be, wd);
    check("lh_value", r, 32'hFFFF8011);
    run_txn(0, 3'd5, 32'h102, 32'h0, 32'h80112233, 5'd0, 0, r, be, wd);
    check("lhu_value", r, 32'h00008011);
    run_txn(1, 3'd0, 32'h201, 32'h000000AB, 32'h0, 5'd9, 0, r, be, wd);
    check("sb_be", be, 4'b0010);
    check("sb_wdata", wd, 32'hABABABAB);
    run_txn(1, 3'd1, 32'h202, 32'h00001234, 32'h0, 5'd9, 1, r, be, wd);
    check("sh_be", be, 4'b1100);
    check("sh_wdata", wd, 32'h12341234);
    run_txn(0, 3'd2, 32'h102, 32'h0, 32'h0, 5'd5, 0, r, be, wd);
    run_txn(1, 3'd1, 32'h203, 32'h1234, 32'h0, 5'd5, 0, r, be, wd);
    run_txn(0, 3'd3, 32'h100, 32'h0, 32'h0, 5'd5, 0, r, be, wd);
    run_txn(0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 5'd12, 5, r, be, wd);
    check("lw_slow_value", r, 32'hCAFEF00D);

    // Reset in the middle of an access, then a stale mem_resp.
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'd2;
    req_addr     = 32'h40;
    req_rd       = 5'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_read_on", mem_read, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_read_off", mem_read, 0);
    check("rstmid_write_off", mem_write, 0);
    check("rstmid_ready", req_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_resp = 1'b0;
    check("late_resp_valid", resp_valid, 0);
    check("late_ready", req_ready, 1);
    @(negedge clk);
    check("late_resp_valid2", resp_valid, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] addr;
      addr = $urandom;
      // Bias toward legal alignments so the memory path gets most of the traffic.
      if ($urandom_range(0, 3) != 0) addr[1:0] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
      run_txn(1'($urandom), 3'($urandom), addr, $urandom, $urandom, 5'($urandom),
              int'($urandom_range(0, 3)), r, be, wd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
